dht11_uart_reporter: RTL and testbench

- Downstream consumer of dht11_controller. On each completed, checksum-valid DHT11 reading it latches the humidity and temperature integer bytes.
- Formats them as a fixed-width ASCII line, for example "H:045 T:023\r\n".
- Pushes the line byte by byte into the UART TX FIFO through a push/full handshake, so sensor readings stream to the PC terminal without CPU involvement.

---
 rtl/dht11_uart_reporter_if.sv | 14 +
 rtl/dht11_uart_reporter.sv | 115 +++++++++++
 tb/tb_dht11_uart_reporter.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/dht11_uart_reporter_if.sv
// Sensor-reading input and UART TX FIFO push/full handshake of dht11_uart_reporter.
interface dht11_uart_reporter_if;
    localparam int unsigned BYTE_W = 8;

    logic              dht_valid;
    logic [BYTE_W-1:0] hum;
    logic [BYTE_W-1:0] tem;
    logic              tx_full;
    logic              tx_push;
    logic [BYTE_W-1:0] tx_data;

    modport master (input dht_valid, hum, tem, tx_full, output tx_push, tx_data);
    modport slave  (output dht_valid, hum, tem, tx_full, input tx_push, tx_data);
endinterface

// File: rtl/dht11_uart_reporter.sv
// Latches each DHT11 reading and streams it as "H:hhh T:ttt[\r\n]" into the UART TX FIFO.
module dht11_uart_reporter #(
    parameter int unsigned EOL_EN = 1,
    parameter int unsigned DROP_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    dht11_uart_reporter_if.master bus,
    output logic                  busy,
    output logic [DROP_W-1:0]     drop_cnt
);
    localparam int unsigned IDX_W  = 4;
    localparam int unsigned BYTE_W = 8;
    localparam logic [IDX_W-1:0] LAST = (EOL_EN != 0) ? IDX_W'(12) : IDX_W'(10);

    typedef enum logic {IDLE, SEND} state_t;

    state_t             state, state_d;
    logic [IDX_W-1:0]   idx, idx_d;
    logic [BYTE_W-1:0]  hum_q, hum_d;
    logic [BYTE_W-1:0]  tem_q, tem_d;
    logic [DROP_W-1:0]  drop_d;
    logic [BYTE_W-1:0]  line_byte;
    logic               push_c;

    // ASCII digit of v at position 0=hundreds, 1=tens, 2=units
    function automatic logic [BYTE_W-1:0] digit_ascii(input logic [BYTE_W-1:0] v,
                                                      input logic [1:0] pos);
        logic [BYTE_W-1:0] d;
        case (pos)
            2'd0:    d = v / 8'd100;
            2'd1:    d = (v / 8'd10) % 8'd10;
            default: d = v % 8'd10;
        endcase
        return 8'h30 + d;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            hum_q    <= '0;
            tem_q    <= '0;
            drop_cnt <= '0;
        end else begin
            state    <= state_d;
            idx      <= idx_d;
            hum_q    <= hum_d;
            tem_q    <= tem_d;
            drop_cnt <= drop_d;
        end
    end

    // Character selected by the current line position
    always_comb begin
        line_byte = 8'h00;
        case (idx)
            4'd0:    line_byte = 8'h48;
            4'd1:    line_byte = 8'h3A;
            4'd2:    line_byte = digit_ascii(hum_q, 2'd0);
            4'd3:    line_byte = digit_ascii(hum_q, 2'd1);
            4'd4:    line_byte = digit_ascii(hum_q, 2'd2);
            4'd5:    line_byte = 8'h20;
            4'd6:    line_byte = 8'h54;
            4'd7:    line_byte = 8'h3A;
            4'd8:    line_byte = digit_ascii(tem_q, 2'd0);
            4'd9:    line_byte = digit_ascii(tem_q, 2'd1);
            4'd10:   line_byte = digit_ascii(tem_q, 2'd2);
            4'd11:   line_byte = 8'h0D;
            4'd12:   line_byte = 8'h0A;
            default: line_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_d     = state;
        idx_d       = idx;
        hum_d       = hum_q;
        tem_d       = tem_q;
        drop_d      = drop_cnt;
        busy        = 1'b0;
        push_c      = 1'b0;
        bus.tx_push = 1'b0;
        bus.tx_data = 8'h00;
        case (state)
            IDLE: begin
                if (bus.dht_valid) begin
                    hum_d   = bus.hum;
                    tem_d   = bus.tem;
                    idx_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                busy        = 1'b1;
                // rst gates the strobe so an abandoned line stops in the reset cycle itself
                push_c      = ~bus.tx_full & ~rst;
                bus.tx_push = push_c;
                bus.tx_data = line_byte;
                if (bus.dht_valid && (drop_cnt != '1)) begin
                    drop_d = drop_cnt + DROP_W'(1);
                end
                if (push_c) begin
                    if (idx == LAST) begin
                        idx_d   = '0;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx + IDX_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_dht11_uart_reporter.sv
// Scoreboard bench for dht11_uart_reporter: instance 1 with CR LF, instance 0 without.
module tb_dht11_uart_reporter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       v    [2];
    logic [7:0] h    [2];
    logic [7:0] t    [2];
    logic       full [2];
    logic       push [2];
    logic [7:0] data [2];
    logic       busy [2];
    logic [7:0] drop [2];

    dht11_uart_reporter_if bus0 ();
    dht11_uart_reporter_if bus1 ();

    assign bus0.dht_valid = v[0];
    assign bus0.hum       = h[0];
    assign bus0.tem       = t[0];
    assign bus0.tx_full   = full[0];
    assign push[0]        = bus0.tx_push;
    assign data[0]        = bus0.tx_data;
    assign bus1.dht_valid = v[1];
    assign bus1.hum       = h[1];
    assign bus1.tem       = t[1];
    assign bus1.tx_full   = full[1];
    assign push[1]        = bus1.tx_push;
    assign data[1]        = bus1.tx_data;

    dht11_uart_reporter #(.EOL_EN(0), .DROP_W(8)) dut_noeol (
        .clk(clk), .rst(rst), .bus(bus0), .busy(busy[0]), .drop_cnt(drop[0]));
    dht11_uart_reporter #(.EOL_EN(1), .DROP_W(8)) dut_eol (
        .clk(clk), .rst(rst), .bus(bus1), .busy(busy[1]), .drop_cnt(drop[1]));

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;
    bit fin = 1'b0;
    bit fin_done = 1'b0;

    // Reference model state: is a line in flight, bytes still owed, dropped count
    bit         m_busy [2];
    int         m_rem  [2];
    logic [7:0] m_drop [2];
    logic [7:0] q0[$];
    logic [7:0] q1[$];

    task automatic chk(input string name, input int i, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, i, act, exp, $time);
        end
    endtask

    task automatic q_push(input int i, input logic [7:0] b);
        if (i == 0) q0.push_back(b); else q1.push_back(b);
    endtask

    function automatic int q_size(input int i);
        return (i == 0) ? q0.size() : q1.size();
    endfunction

    // Expected text of one reading: fixed three-digit decimal fields
    task automatic line_push(input int i, input int hv, input int tv);
        q_push(i, "H"); q_push(i, ":");
        q_push(i, 8'(48 + hv / 100)); q_push(i, 8'(48 + (hv / 10) % 10)); q_push(i, 8'(48 + hv % 10));
        q_push(i, " "); q_push(i, "T"); q_push(i, ":");
        q_push(i, 8'(48 + tv / 100)); q_push(i, 8'(48 + (tv / 10) % 10)); q_push(i, 8'(48 + tv % 10));
        if (i == 1) begin
            q_push(i, 8'h0D); q_push(i, 8'h0A);
        end
    endtask

    task automatic mon_step(input int i);
        logic [7:0] exp_b;
        chk("tx_push", i, int'(push[i]), int'(m_busy[i] && !full[i] && !rst));
        if (push[i] === 1'b1) begin
            if (q_size(i) == 0) begin
                chk("extra_byte", i, int'(data[i]), -1);
            end else begin
                if (i == 0) exp_b = q0.pop_front(); else exp_b = q1.pop_front();
                chk("tx_data", i, int'(data[i]), int'(exp_b));
            end
        end
        if (chk_en) begin
            chk("busy", i, int'(busy[i]), int'(m_busy[i]));
            chk("drop_cnt", i, int'(drop[i]), int'(m_drop[i]));
        end
    endtask

    task automatic model_step(input int i);
        bit acc;
        if (rst) begin
            m_busy[i] = 1'b0;
            m_rem[i]  = 0;
            m_drop[i] = 8'h00;
            if (i == 0) q0.delete(); else q1.delete();
            return;
        end
        acc = !m_busy[i] && v[i];
        if (m_busy[i]) begin
            if (v[i] && m_drop[i] != 8'hFF) m_drop[i] = m_drop[i] + 8'd1;
            if (!full[i]) begin
                m_rem[i]--;
                if (m_rem[i] == 0) m_busy[i] = 1'b0;
            end
        end
        if (acc) begin
            line_push(i, int'(h[i]), int'(t[i]));
            m_rem[i]  = (i == 1) ? 13 : 11;
            m_busy[i] = 1'b1;
        end
    endtask

    // Monitor checks what the DUT shows this cycle, then the model absorbs this cycle's inputs
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) mon_step(i);
        for (int i = 0; i < 2; i++) model_step(i);
        if (fin && !fin_done) begin
            fin_done = 1'b1;
            for (int i = 0; i < 2; i++) chk("leftover_bytes", i, q_size(i), 0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int i, input logic [7:0] hh, input logic [7:0] tt);
        v[i] = 1'b1; h[i] = hh; t[i] = tt;
        step();
        v[i] = 1'b0; h[i] = 8'($urandom); t[i] = 8'($urandom);
    endtask

    task automatic wait_idle(input int i);
        for (int k = 0; k < 400; k++) begin
            if (!m_busy[i]) begin
                step();
                return;
            end
            step();
        end
        $display("FAIL wait_idle dut%0d: line still open after 400 cycles", i);
        $fatal(1, "timeout");
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            v[i] = 1'b0; h[i] = 8'h00; t[i] = 8'h00; full[i] = 1'b0;
        end
        step(); step();
        rst = 1'b0;
        chk_en = 1'b1;
        step();

        // Basic lines and digit boundaries
        pulse(1, 8'd45, 8'd23);  wait_idle(1);
        pulse(1, 8'd255, 8'd0);  wait_idle(1);
        pulse(1, 8'd7, 8'd100);  wait_idle(1);

        // FIFO full while idx 3 is pending
        pulse(1, 8'd45, 8'd23);
        step(); step(); step();
        full[1] = 1'b1;
        repeat (5) step();
        full[1] = 1'b0;
        wait_idle(1);

        // Three pulses during a line are dropped, the next one starts a new line
        pulse(1, 8'd45, 8'd23);
        step(); pulse(1, 8'd99, 8'd98);
        step(); pulse(1, 8'd97, 8'd96);
        step(); pulse(1, 8'd95, 8'd94);
        wait_idle(1);
        pulse(1, 8'd61, 8'd19);  wait_idle(1);

        // Saturate the drop counter
        pulse(1, 8'd1, 8'd2);
        full[1] = 1'b1;
        for (int k = 0; k < 261; k++) begin
            v[1] = 1'b1; step();
            v[1] = 1'b0; step();
        end
        full[1] = 1'b0;
        wait_idle(1);

        // Reset after the fifth byte abandons the line
        pulse(1, 8'd45, 8'd23);
        repeat (5) step();
        rst = 1'b1; step();
        rst = 1'b0; step();
        pulse(1, 8'd88, 8'd5);   wait_idle(1);

        // Instance without line ending
        pulse(0, 8'd12, 8'd34);  wait_idle(0);

        // Random readings, overlaps and back-pressure on both instances
        for (int k = 0; k < 600; k++) begin
            for (int i = 0; i < 2; i++) begin
                v[i]    = ($urandom_range(0, 9) == 0);
                h[i]    = 8'($urandom);
                t[i]    = 8'($urandom);
                full[i] = ($urandom_range(0, 3) == 0);
            end
            step();
        end
        for (int i = 0; i < 2; i++) begin
            v[i] = 1'b0; full[i] = 1'b0;
        end
        wait_idle(0);
        wait_idle(1);

        fin = 1'b1;
        step(); step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
